// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM and the datapath:
// instruction fields and memory handshake in, every datapath select/enable out.
interface mips_mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] AluSel;
  logic       ExtOp;
  logic       InstrDone;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, AluSrcA, AluSrcB, AluSel, ExtOp, InstrDone,
           IllegalOp, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, AluSrcA, AluSrcB, AluSel, ExtOp, InstrDone,
           IllegalOp, State
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Main control FSM of the multicycle MIPS core. Only the state is registered;
// every control output is a decode of the state (plus MemReady/Op where needed).
module mips_mc_ctrl #(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_REXE   = 4'd7,
    S_RWB    = 4'd8,  S_BEQEX = 4'd9,  S_IEXE   = 4'd10, S_IWB    = 4'd11,
    S_JEX    = 4'd12
  } state_t;

  state_t state_r;
  logic   mem_ready_s;
  logic   op_lw_s, op_sw_s, op_r_s, op_beq_s, op_j_s, op_imm_s, op_zext_s;
  logic   funct_ok_s, illegal_s, valid_s;

  assign mem_ready_s = MEM_WAIT ? bus.MemReady : 1'b1;

  assign op_lw_s   = (bus.Op == 6'b100011);
  assign op_sw_s   = (bus.Op == 6'b101011);
  assign op_r_s    = (bus.Op == 6'b000000);
  assign op_beq_s  = (bus.Op == 6'b000100);
  assign op_j_s    = (bus.Op == 6'b000010);
  assign op_zext_s = (bus.Op == 6'b001100) || (bus.Op == 6'b001101);
  assign op_imm_s  = op_zext_s || (bus.Op == 6'b001000) || (bus.Op == 6'b001010);

  assign funct_ok_s = (bus.Funct == 6'b100000) || (bus.Funct == 6'b100010) ||
                      (bus.Funct == 6'b100100) || (bus.Funct == 6'b100101) ||
                      (bus.Funct == 6'b101010) || (bus.Funct == 6'b000000);

  assign illegal_s = !(op_lw_s || op_sw_s || op_beq_s || op_j_s || op_imm_s ||
                       (op_r_s && funct_ok_s));

  // RST and the unused codes 13-15 drive everything low, including ExtOp
  assign valid_s   = (state_r != S_RST) && (state_r <= S_JEX);
  assign bus.State = state_r;

  // State sequencing; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RST;
    end else begin
      case (state_r)
        S_RST:    state_r <= S_FETCH;
        S_FETCH:  state_r <= mem_ready_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (illegal_s)                  state_r <= S_FETCH;
          else if (op_lw_s || op_sw_s)    state_r <= S_MEMADR;
          else if (op_r_s)                state_r <= S_REXE;
          else if (op_beq_s)              state_r <= S_BEQEX;
          else if (op_imm_s)              state_r <= S_IEXE;
          else if (op_j_s)                state_r <= S_JEX;
          else                            state_r <= S_FETCH;
        end
        S_MEMADR: state_r <= op_sw_s ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_r <= mem_ready_s ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_r <= S_FETCH;
        S_MEMWR:  state_r <= mem_ready_s ? S_FETCH : S_MEMWR;
        S_REXE:   state_r <= S_RWB;
        S_RWB:    state_r <= S_FETCH;
        S_BEQEX:  state_r <= S_FETCH;
        S_IEXE:   state_r <= S_IWB;
        S_IWB:    state_r <= S_FETCH;
        S_JEX:    state_r <= S_FETCH;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  // Datapath control decode from the current state
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.Branch    = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.AluSrcA   = 1'b0;
    bus.AluSrcB   = 2'b00;
    bus.AluSel    = 2'b00;
    bus.ExtOp     = valid_s;
    bus.InstrDone = 1'b0;
    bus.IllegalOp = 1'b0;
    case (state_r)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.AluSrcB = 2'b01;
        bus.IRWrite = mem_ready_s;
        bus.PCWrite = mem_ready_s;
      end
      S_DECODE: begin
        bus.AluSrcB   = 2'b11;
        bus.IllegalOp = illegal_s;
      end
      S_MEMADR: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg  = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD      = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.InstrDone = mem_ready_s;
      end
      S_REXE: begin
        bus.AluSrcA = 1'b1;
        bus.AluSel  = 2'b10;
      end
      S_RWB: begin
        bus.RegDst    = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BEQEX: begin
        bus.AluSrcA   = 1'b1;
        bus.AluSel    = 2'b01;
        bus.Branch    = 1'b1;
        bus.PCSrc     = 2'b01;
        bus.InstrDone = 1'b1;
      end
      S_IEXE: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = 2'b10;
        bus.AluSel  = 2'b10;
        bus.ExtOp   = !op_zext_s;
      end
      S_IWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_JEX: begin
        bus.PCSrc     = 2'b10;
        bus.PCWrite   = 1'b1;
        bus.InstrDone = 1'b1;
      end
      default: begin
        bus.ExtOp = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control vector and MemReady pattern.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] alusel;
    logic       extop;
    logic       instrdone;
    logic       illegalop;
    logic [3:0] state;
  } ctl_t;

  typedef struct {
    ctl_t       e;
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
  localparam logic [5:0] LEGAL_OPS [8] = '{LW, SW, RT, BEQ, JMP, ADDI, ANDI, ORI};
  localparam logic [5:0] R_FN [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  step_t q[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.MEM_WAIT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t o;
    o = '{bus.PCWrite, bus.Branch, bus.PCSrc, bus.IorD, bus.MemRead, bus.MemWrite,
          bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.AluSrcA,
          bus.AluSrcB, bus.AluSel, bus.ExtOp, bus.InstrDone, bus.IllegalOp, bus.State};
    return o;
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    bit ok = 1'b0;
    if (op == SLTI) ok = 1'b1;
    for (int i = 0; i < 8; i++) if (op == LEGAL_OPS[i]) ok = 1'b1;
    if (op == RT) begin
      ok = 1'b0;
      for (int i = 0; i < 6; i++) if (fn == R_FN[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic ctl_t base(input int st);
    ctl_t e = '0;
    e.extop = 1'b1;
    e.state = 4'(st);
    return e;
  endfunction

  task automatic push(input ctl_t e, input logic mr, input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.e = e; s.mr = mr; s.op = op; s.fn = fn;
    q.push_back(s);
  endtask

  // Expand one instruction: wf fetch stalls, wm memory stalls
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    ctl_t e;
    for (int i = 0; i <= wf; i++) begin
      e = base(1); e.memread = 1'b1; e.alusrcb = 2'b01;
      if (i == wf) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
      push(e, 1'(i == wf), 6'($urandom), 6'($urandom));
    end
    e = base(2); e.alusrcb = 2'b11; e.illegalop = !legal(op, fn);
    push(e, 1'($urandom), op, fn);
    if (!legal(op, fn)) return;
    if (op == LW || op == SW) begin
      e = base(3); e.alusrca = 1'b1; e.alusrcb = 2'b10;
      push(e, 1'($urandom), op, fn);
      for (int i = 0; i <= wm; i++) begin
        e = base(op == LW ? 4 : 6); e.iord = 1'b1;
        if (op == LW) e.memread = 1'b1;
        else begin e.memwrite = 1'b1; e.instrdone = 1'(i == wm); end
        push(e, 1'(i == wm), op, fn);
      end
      if (op == LW) begin
        e = base(5); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instrdone = 1'b1;
        push(e, 1'($urandom), op, fn);
      end
    end else if (op == RT) begin
      e = base(7); e.alusrca = 1'b1; e.alusel = 2'b10;
      push(e, 1'($urandom), op, fn);
      e = base(8); e.regdst = 1'b1; e.regwrite = 1'b1; e.instrdone = 1'b1;
      push(e, 1'($urandom), op, fn);
    end else if (op == BEQ) begin
      e = base(9); e.alusrca = 1'b1; e.alusel = 2'b01; e.branch = 1'b1;
      e.pcsrc = 2'b01; e.instrdone = 1'b1;
      push(e, 1'($urandom), op, fn);
    end else if (op == JMP) begin
      e = base(12); e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.instrdone = 1'b1;
      push(e, 1'($urandom), op, fn);
    end else begin
      e = base(10); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alusel = 2'b10;
      e.extop = !(op == ANDI || op == ORI);
      push(e, 1'($urandom), op, fn);
      e = base(11); e.regwrite = 1'b1; e.instrdone = 1'b1;
      push(e, 1'($urandom), op, fn);
    end
  endtask

  // Play the queue one cycle per entry; optionally reset during the first cycle in abort_st
  task automatic run_q(input int abort_st);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.Op = s.op; bus.Funct = s.fn; bus.MemReady = s.mr;
      #1;
      chk($sformatf("st%0d", s.e.state), observed(), s.e);
      if (abort_st > 0 && int'(s.e.state) == abort_st) begin
        reset = 1'b1;
        #1 chk("rst_async", observed(), '0);
        @(posedge clk); #1;
        chk("rst_hold", observed(), '0);
        reset = 1'b0;
        #1 chk("rst_release", observed(), '0);
        @(posedge clk); #1;
        q.delete();
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_instr();
    logic [5:0] op, fn;
    int k = $urandom_range(0, 10);
    fn = 6'($urandom);
    case (k)
      0: op = LW;
      1: op = SW;
      2: begin op = RT; fn = R_FN[$urandom_range(0, 5)]; end
      3: begin op = RT; while (legal(op, fn)) fn = 6'($urandom); end
      4: op = BEQ;
      5: op = JMP;
      6: op = ADDI;
      7: op = ANDI;
      8: op = ORI;
      9: op = SLTI;
      default: begin op = 6'($urandom); while (legal(op, fn)) op = 6'($urandom); end
    endcase
    gen(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  initial begin
    reset = 1'b1;
    bus.Op = 6'b0; bus.Funct = 6'b0; bus.MemReady = 1'b0;
    #2 chk("rst_init", observed(), '0);
    @(posedge clk); #1;
    chk("rst_init_hold", observed(), '0);
    reset = 1'b0;
    #1 chk("rst_state", observed(), '0);
    @(posedge clk); #1;

    gen(SW, 6'd5, 0, 3);
    run_q(6);
    gen(LW, 6'd0, 0, 0);         run_q(0);
    gen(SW, 6'd1, 0, 3);         run_q(0);
    gen(RT, 6'b100010, 0, 0);    run_q(0);
    gen(RT, 6'b111111, 0, 0);    run_q(0);
    gen(ORI, 6'd7, 0, 0);        run_q(0);
    gen(ADDI, 6'd7, 0, 0);       run_q(0);
    gen(BEQ, 6'd3, 1, 0);        run_q(0);
    gen(JMP, 6'd9, 2, 0);        run_q(0);
    gen(LW, 6'd4, 1, 2);         run_q(0);
    gen(6'b111111, 6'd0, 0, 0);  run_q(0);

    for (int i = 0; i < 80; i++) begin
      rand_instr();
      run_q(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
